// File: rtl/sobel_window_feeder_pkg.sv
// Shared constants and helpers for the Sobel pixel-feed path.
// Pixel type, default image geometry and line-slot arithmetic.
package sobel_window_feeder_pkg;

   localparam int PIXEL_WIDTH     = 8;
   localparam int IMG_WIDTH_DFLT  = 16;
   localparam int IMG_HEIGHT_DFLT = 16;

   typedef logic [PIXEL_WIDTH-1:0] pixel_t;

   // (a + b) mod 3 for line-buffer slot indices
   function automatic logic [1:0] slot_add(
      input logic [1:0] a,
      input logic [1:0] b
   );
      logic [2:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
   endfunction

endpackage

// File: rtl/sobel_window_feeder_if.sv
// Pixel stream bundle: raster input handshake plus Sobel output stream.
// master = feeder side, slave = the surrounding producer/consumer.
interface sobel_window_feeder_if
   import sobel_window_feeder_pkg::*;
();

   logic   in_valid_i;
   pixel_t in_px_i;
   logic   in_ready_o;
   logic   start_sobel_o;
   logic   px_rdy_o;
   pixel_t out_px_o;

   modport master (
      input  in_valid_i,
      input  in_px_i,
      output in_ready_o,
      output start_sobel_o,
      output px_rdy_o,
      output out_px_o
   );

   modport slave (
      output in_valid_i,
      output in_px_i,
      input  in_ready_o,
      input  start_sobel_o,
      input  px_rdy_o,
      input  out_px_o
   );

endinterface

// File: rtl/sobel_line_buffer.sv
// Three-line pixel store: one write port, one combinational read port.
// Slots are addressed 0..2; slot 3 never occurs and reads as zero.
module sobel_line_buffer
   import sobel_window_feeder_pkg::*;
#(
   parameter int IMG_WIDTH = IMG_WIDTH_DFLT
)(
   input  logic                         clk_i,
   input  logic                         nreset_i,
   input  logic                         we,
   input  logic [1:0]                   wr_slot,
   input  logic [$clog2(IMG_WIDTH)-1:0] wr_col,
   input  pixel_t                       wr_px,
   input  logic [1:0]                   rd_slot,
   input  logic [$clog2(IMG_WIDTH)-1:0] rd_col,
   output pixel_t                       rd_px
);

   pixel_t mem [3][IMG_WIDTH];

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         for (int s = 0; s < 3; s++) begin
            for (int c = 0; c < IMG_WIDTH; c++) begin
               mem[s][c] <= '0;
            end
         end
      end else if (we && wr_slot != 2'd3) begin
         mem[wr_slot][wr_col] <= wr_px;
      end
   end

   always_comb begin
      rd_px = '0;
      if (rd_slot != 2'd3) begin
         rd_px = mem[rd_slot][rd_col];
      end
   end

endmodule

// File: rtl/sobel_window_feeder.sv
// Turns a raster grayscale frame into per-row column-triple streams
// for the Sobel window, using a rotating three-line buffer.
module sobel_window_feeder
   import sobel_window_feeder_pkg::*;
#(
   parameter int IMG_WIDTH  = IMG_WIDTH_DFLT,
   parameter int IMG_HEIGHT = IMG_HEIGHT_DFLT,
   parameter int GAP_CYCLES = 2
)(
   input  logic                  clk_i,
   input  logic                  nreset_i,
   input  logic                  start_frame_i,
   sobel_window_feeder_if.master px_if,
   output logic                  busy_o,
   output logic                  frame_done_o
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);

   localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT);
   localparam logic [RW-1:0] ROW_PRE  = RW'(2);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [GW-1:0] GAP_MAX  = GW'(GAP_CYCLES);

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      STREAM,
      REFILL,
      DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] col;
   logic [RW-1:0] row_in;
   logic [1:0]    top;
   logic [1:0]    lane;
   logic [CW-1:0] scol;
   logic [GW-1:0] gap;
   logic          rfull;

   logic          xfer;
   logic          col_end;
   logic          full_now;
   logic          last_px;
   logic [1:0]    nxt_lane;
   logic [CW-1:0] nxt_scol;
   logic [1:0]    wr_slot;
   logic [1:0]    rd_slot;
   logic [CW-1:0] rd_col;
   pixel_t        rd_px;

   assign xfer     = px_if.in_valid_i & px_if.in_ready_o;
   assign col_end  = (col == COL_LAST);
   assign full_now = rfull | (xfer & col_end);
   assign last_px  = (lane == 2'd2) && (scol == COL_LAST);

   // Read address is the pixel that goes out on the next cycle
   always_comb begin
      nxt_lane = lane + 2'd1;
      nxt_scol = scol;
      if (lane == 2'd2) begin
         nxt_lane = 2'd0;
         nxt_scol = scol + 1'b1;
      end
      wr_slot = (state == FILL) ? row_in[1:0] : top;
      rd_slot = slot_add(top, nxt_lane);
      rd_col  = nxt_scol;
      if (state == REFILL) begin
         rd_slot = slot_add(top, 2'd1);
         rd_col  = '0;
      end else if (state != STREAM) begin
         rd_slot = top;
         rd_col  = '0;
      end
   end

   sobel_line_buffer #(
      .IMG_WIDTH (IMG_WIDTH)
   ) u_lbuf (
      .clk_i    (clk_i),
      .nreset_i (nreset_i),
      .we       (xfer),
      .wr_slot  (wr_slot),
      .wr_col   (col),
      .wr_px    (px_if.in_px_i),
      .rd_slot  (rd_slot),
      .rd_col   (rd_col),
      .rd_px    (rd_px)
   );

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state               <= IDLE;
         col                 <= '0;
         row_in              <= '0;
         top                 <= '0;
         lane                <= '0;
         scol                <= '0;
         gap                 <= '0;
         rfull               <= 1'b0;
         busy_o              <= 1'b0;
         frame_done_o        <= 1'b0;
         px_if.in_ready_o    <= 1'b0;
         px_if.start_sobel_o <= 1'b0;
         px_if.px_rdy_o      <= 1'b0;
         px_if.out_px_o      <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start_frame_i) begin
                  state            <= FILL;
                  busy_o           <= 1'b1;
                  px_if.in_ready_o <= 1'b1;
                  row_in           <= '0;
                  col              <= '0;
                  top              <= '0;
               end
            end
            FILL: begin
               if (xfer) begin
                  col <= col_end ? '0 : col + 1'b1;
                  if (col_end) begin
                     row_in <= row_in + 1'b1;
                  end
                  if (col_end && row_in == ROW_PRE) begin
                     state               <= STREAM;
                     px_if.in_ready_o    <= 1'b0;
                     px_if.start_sobel_o <= 1'b1;
                     px_if.px_rdy_o      <= 1'b1;
                     px_if.out_px_o      <= rd_px;
                     lane                <= '0;
                     scol                <= '0;
                  end
               end
            end
            STREAM: begin
               if (last_px) begin
                  px_if.start_sobel_o <= 1'b0;
                  px_if.px_rdy_o      <= 1'b0;
                  if (row_in == ROW_LAST) begin
                     state        <= DONE;
                     frame_done_o <= 1'b1;
                  end else begin
                     state            <= REFILL;
                     px_if.in_ready_o <= 1'b1;
                     col              <= '0;
                     gap              <= '0;
                     rfull            <= 1'b0;
                  end
               end else begin
                  lane           <= nxt_lane;
                  scol           <= nxt_scol;
                  px_if.out_px_o <= rd_px;
               end
            end
            REFILL: begin
               if (gap != GAP_MAX) begin
                  gap <= gap + 1'b1;
               end
               if (xfer) begin
                  col <= col_end ? '0 : col + 1'b1;
                  if (col_end) begin
                     rfull <= 1'b1;
                  end
               end
               if (full_now && gap >= GAP_LAST) begin
                  state               <= STREAM;
                  top                 <= slot_add(top, 2'd1);
                  row_in              <= row_in + 1'b1;
                  px_if.in_ready_o    <= 1'b0;
                  px_if.start_sobel_o <= 1'b1;
                  px_if.px_rdy_o      <= 1'b1;
                  px_if.out_px_o      <= rd_px;
                  lane                <= '0;
                  scol                <= '0;
               end else if (full_now) begin
                  px_if.in_ready_o <= 1'b0;
               end
            end
            DONE: begin
               state        <= IDLE;
               frame_done_o <= 1'b0;
               busy_o       <= 1'b0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
